// File: rtl/lift_dispatcher_if.sv
// rtl/lift_dispatcher_if.sv - request, car handshake and status bundle for the lift dispatcher
interface lift_dispatcher_if;
    logic       emergency_stop;
    logic       req_valid;
    logic [2:0] req_floor;
    logic [2:0] car_floor;
    logic       car_at_target;
    logic [2:0] target_floor;
    logic       move_en;
    logic       dir_up;
    logic       door_open;
    logic [7:0] pending;

    modport master (
        output emergency_stop, req_valid, req_floor, car_floor, car_at_target,
        input  target_floor, move_en, dir_up, door_open, pending
    );

    modport slave (
        input  emergency_stop, req_valid, req_floor, car_floor, car_at_target,
        output target_floor, move_en, dir_up, door_open, pending
    );
endinterface

// File: rtl/lift_dispatcher.sv
// rtl/lift_dispatcher.sv - SCAN request scheduler with move/arrive handshake and door dwell
module lift_dispatcher #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    lift_dispatcher_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, SELECT, MOVE, DWELL, ESTOP} state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] target_q, target_d;
    logic       move_en_q, move_en_d;
    logic       dir_up_q, dir_up_d;
    logic       door_open_q, door_open_d;
    logic [7:0] cnt_q, cnt_d;

    logic       any_ge, any_lt, any_le, any_gt;
    logic [2:0] lo_ge, hi_lt, hi_le, lo_gt;
    logic [2:0] sel_floor;
    logic       sel_dir;
    logic [7:0] set_mask, clr_mask;

    // Nearest pending floor on each side of the car; ascending scan keeps the
    // last (highest) hit, descending scan keeps the last (lowest) hit.
    always_comb begin
        any_ge = 1'b0; any_lt = 1'b0; any_le = 1'b0; any_gt = 1'b0;
        lo_ge  = 3'd0; hi_lt  = 3'd0; hi_le  = 3'd0; lo_gt  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i] && (3'(i) < bus.car_floor)) begin
                any_lt = 1'b1; hi_lt = 3'(i);
            end
            if (pending_q[i] && (3'(i) <= bus.car_floor)) begin
                any_le = 1'b1; hi_le = 3'(i);
            end
        end
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i] && (3'(i) >= bus.car_floor)) begin
                any_ge = 1'b1; lo_ge = 3'(i);
            end
            if (pending_q[i] && (3'(i) > bus.car_floor)) begin
                any_gt = 1'b1; lo_gt = 3'(i);
            end
        end
        sel_floor = 3'd0;
        sel_dir   = dir_up_q;
        if (dir_up_q) begin
            if (any_ge) sel_floor = lo_ge;
            else begin sel_floor = hi_lt; sel_dir = 1'b0; end
        end else begin
            if (any_le) sel_floor = hi_le;
            else begin sel_floor = lo_gt; sel_dir = 1'b1; end
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        move_en_d   = move_en_q;
        dir_up_d    = dir_up_q;
        door_open_d = door_open_q;
        cnt_d       = cnt_q;
        clr_mask    = 8'h00;
        set_mask    = 8'h00;
        // A call for the floor the door is already open at is served by this stop.
        if (bus.req_valid && !(state_q == DWELL && bus.req_floor == bus.car_floor))
            set_mask = 8'h01 << bus.req_floor;

        case (state_q)
            IDLE: if (pending_q != 8'h00) state_d = SELECT;
            SELECT: begin
                if (pending_q == 8'h00) begin
                    state_d = IDLE;
                end else begin
                    dir_up_d = sel_dir;
                    if (sel_floor == bus.car_floor) begin
                        clr_mask    = 8'h01 << sel_floor;
                        cnt_d       = 8'(DWELL_CYCLES - 1);
                        door_open_d = 1'b1;
                        state_d     = DWELL;
                    end else begin
                        target_d  = sel_floor;
                        move_en_d = 1'b1;
                        state_d   = MOVE;
                    end
                end
            end
            MOVE: if (bus.car_at_target) begin
                clr_mask    = 8'h01 << target_q;
                move_en_d   = 1'b0;
                cnt_d       = 8'(DWELL_CYCLES - 1);
                door_open_d = 1'b1;
                state_d     = DWELL;
            end
            DWELL: begin
                if (cnt_q == 8'd0) begin
                    door_open_d = 1'b0;
                    state_d     = SELECT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ESTOP: if (!bus.emergency_stop) state_d = SELECT;
            default: state_d = IDLE;
        endcase

        // Emergency stop overrides every transition but still lets requests latch.
        if (bus.emergency_stop) begin
            state_d     = ESTOP;
            move_en_d   = 1'b0;
            door_open_d = 1'b0;
            target_d    = target_q;
            dir_up_d    = dir_up_q;
            cnt_d       = cnt_q;
            clr_mask    = 8'h00;
        end
        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 8'h00;
            target_q    <= 3'd0;
            move_en_q   <= 1'b0;
            dir_up_q    <= 1'b1;
            door_open_q <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            target_q    <= target_d;
            move_en_q   <= move_en_d;
            dir_up_q    <= dir_up_d;
            door_open_q <= door_open_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.target_floor = target_q;
    assign bus.move_en      = move_en_q;
    assign bus.dir_up       = dir_up_q;
    assign bus.door_open    = door_open_q;
    assign bus.pending      = pending_q;
endmodule

// File: tb/tb_lift_dispatcher.sv
// tb/tb_lift_dispatcher.sv - directed vector table plus SCAN and emergency-stop sequences
module tb_lift_dispatcher;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    lift_dispatcher_if bus ();
    lift_dispatcher #(.DWELL_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, es, rv;
        logic [2:0] rf, cf;
        logic       cat;
        logic       em;
        logic [2:0] et;
        logic       ed, edoor;
        logic [7:0] ep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic es, logic rv, logic [2:0] rf, logic [2:0] cf,
                                logic cat, logic em, logic [2:0] et, logic ed, logic edoor,
                                logic [7:0] ep);
        vec_t v;
        v.rst = rst; v.es = es; v.rv = rv; v.rf = rf; v.cf = cf; v.cat = cat;
        v.em = em; v.et = et; v.ed = ed; v.edoor = edoor; v.ep = ep;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic es, logic rv, logic [2:0] rf, logic [2:0] cf, logic cat);
        reset              = rst;
        bus.emergency_stop = es;
        bus.req_valid      = rv;
        bus.req_floor      = rf;
        bus.car_floor      = cf;
        bus.car_at_target  = cat;
        @(posedge clk);
        #1;
    endtask

    task automatic arrive(logic [2:0] floor, logic [7:0] exp_pend);
        drive(1'b0, 1'b0, 1'b0, 3'd0, floor, 1'b1);
        chk($sformatf("arrive%0d door_open", floor), {7'b0, bus.door_open}, 8'h01);
        chk($sformatf("arrive%0d pending", floor), bus.pending, exp_pend);
    endtask

    task automatic wait_move(logic [2:0] floor, logic [2:0] exp_tgt, logic exp_dir);
        int n = 0;
        while (!bus.move_en && n < 20) begin
            drive(1'b0, 1'b0, 1'b0, 3'd0, floor, 1'b0);
            n++;
        end
        chk($sformatf("move_to%0d timeout", exp_tgt), {7'b0, bus.move_en}, 8'h01);
        chk($sformatf("move_to%0d target", exp_tgt), {5'b0, bus.target_floor}, {5'b0, exp_tgt});
        chk($sformatf("move_to%0d dir_up", exp_tgt), {7'b0, bus.dir_up}, {7'b0, exp_dir});
    endtask

    initial begin
        reset = 1'b1;
        bus.emergency_stop = 1'b0; bus.req_valid = 1'b0; bus.req_floor = 3'd0;
        bus.car_floor = 3'd0; bus.car_at_target = 1'b0;

        // basic service: request 3 from floor 0, arrival, 4-cycle dwell, idle
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,1,0,8'h00));
        vecs.push_back(mk(0,0,1,3,0,0, 0,0,1,0,8'h08));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0,8'h08));
        vecs.push_back(mk(0,0,0,0,0,0, 1,3,1,0,8'h08));
        vecs.push_back(mk(0,0,0,0,0,0, 1,3,1,0,8'h08));
        vecs.push_back(mk(0,0,0,0,3,1, 0,3,1,1,8'h00));
        vecs.push_back(mk(0,0,0,0,3,0, 0,3,1,1,8'h00));
        vecs.push_back(mk(0,0,0,0,3,0, 0,3,1,1,8'h00));
        vecs.push_back(mk(0,0,0,0,3,0, 0,3,1,1,8'h00));
        vecs.push_back(mk(0,0,0,0,3,0, 0,3,1,0,8'h00));
        vecs.push_back(mk(0,0,0,0,3,0, 0,3,1,0,8'h00));
        vecs.push_back(mk(0,0,0,0,3,1, 0,3,1,0,8'h00));
        // same-floor request, and a repeat of it during the dwell is dropped
        vecs.push_back(mk(0,0,1,4,4,0, 0,3,1,0,8'h10));
        vecs.push_back(mk(0,0,0,0,4,0, 0,3,1,0,8'h10));
        vecs.push_back(mk(0,0,0,0,4,0, 0,3,1,1,8'h00));
        vecs.push_back(mk(0,0,1,4,4,0, 0,3,1,1,8'h00));
        vecs.push_back(mk(0,0,0,0,4,0, 0,3,1,1,8'h00));
        vecs.push_back(mk(0,0,0,0,4,0, 0,3,1,1,8'h00));
        vecs.push_back(mk(0,0,0,0,4,0, 0,3,1,0,8'h00));
        vecs.push_back(mk(0,0,0,0,4,0, 0,3,1,0,8'h00));
        // reset during a dwell with pending 0x0C
        vecs.push_back(mk(0,0,1,4,4,0, 0,3,1,0,8'h10));
        vecs.push_back(mk(0,0,0,0,4,0, 0,3,1,0,8'h10));
        vecs.push_back(mk(0,0,0,0,4,0, 0,3,1,1,8'h00));
        vecs.push_back(mk(0,0,1,2,4,0, 0,3,1,1,8'h04));
        vecs.push_back(mk(0,0,1,3,4,0, 0,3,1,1,8'h0C));
        vecs.push_back(mk(1,0,0,0,4,0, 0,0,1,0,8'h00));
        vecs.push_back(mk(0,0,0,0,4,0, 0,0,1,0,8'h00));
        // arrival and a request for the same floor on one edge: clear wins
        vecs.push_back(mk(0,0,1,6,0,0, 0,0,1,0,8'h40));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0,8'h40));
        vecs.push_back(mk(0,0,0,0,0,0, 1,6,1,0,8'h40));
        vecs.push_back(mk(0,0,1,6,6,1, 0,6,1,1,8'h00));
        vecs.push_back(mk(0,0,0,0,6,0, 0,6,1,1,8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].es, vecs[i].rv, vecs[i].rf, vecs[i].cf, vecs[i].cat);
            chk($sformatf("v%0d move_en", i), {7'b0, bus.move_en}, {7'b0, vecs[i].em});
            chk($sformatf("v%0d target", i), {5'b0, bus.target_floor}, {5'b0, vecs[i].et});
            chk($sformatf("v%0d dir_up", i), {7'b0, bus.dir_up}, {7'b0, vecs[i].ed});
            chk($sformatf("v%0d door_open", i), {7'b0, bus.door_open}, {7'b0, vecs[i].edoor});
            chk($sformatf("v%0d pending", i), bus.pending, vecs[i].ep);
        end

        // SCAN order from floor 2 going up with {1,5,6}: 5, 6, 1, then 4
        drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 3'd1, 3'd2, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 3'd5, 3'd2, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 3'd6, 3'd2, 1'b0);
        chk("scan preload pending", bus.pending, 8'h62);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0);
        wait_move(3'd2, 3'd5, 1'b1);
        arrive(3'd5, 8'h42);
        wait_move(3'd5, 3'd6, 1'b1);
        arrive(3'd6, 8'h02);
        wait_move(3'd6, 3'd1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3'd4, 3'd5, 1'b0);
        chk("scan late req pending", bus.pending, 8'h12);
        arrive(3'd1, 8'h10);
        wait_move(3'd1, 3'd4, 1'b1);
        arrive(3'd4, 8'h00);

        // emergency stop while moving to 5 with 7 pending
        drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3'd5, 3'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3'd7, 3'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0);
        chk("estop pre move_en", {7'b0, bus.move_en}, 8'h01);
        chk("estop pre target", {5'b0, bus.target_floor}, 8'h05);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 1'b0);
        chk("estop move_en", {7'b0, bus.move_en}, 8'h00);
        chk("estop door_open", {7'b0, bus.door_open}, 8'h00);
        chk("estop pending held", bus.pending, 8'hA0);
        chk("estop target held", {5'b0, bus.target_floor}, 8'h05);
        drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd3, 1'b0);
        chk("estop req latch", bus.pending, 8'hA1);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 1'b0);
        chk("estop release select move_en", {7'b0, bus.move_en}, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 1'b0);
        chk("estop resume move_en", {7'b0, bus.move_en}, 8'h01);
        chk("estop resume target", {5'b0, bus.target_floor}, 8'h05);
        chk("estop resume dir_up", {7'b0, bus.dir_up}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
